huffman_coder_ctrl: RTL

- Sequencer for the 32-bit Huffman bit-packer (`coder`): accepts a byte-symbol stream, looks up `{length, code}` in an on-chip 256-entry table, and drives `coder` ce/resetn/code/length one beat per cycle.
- Mirrors `coder`'s accumulated-length register internally, so it knows when a packed word appears; captures it into a 2-deep output FIFO with valid/ready.
- On end of message, zero-pads to a 32-bit boundary and forces the final word out.

---
 rtl/huffman_coder_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/huffman_coder_ctrl.sv
// Sequencer for the 32-bit Huffman bit-packer: symbol table lookup, coder beat
// issue, mirrored length accounting, end-of-message padding and output FIFO.
module huffman_coder_ctrl #(
  parameter int unsigned TBL_AW     = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              tbl_we,
  input  logic [TBL_AW-1:0] tbl_addr,
  input  logic [11:0]       tbl_wdata,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [TBL_AW-1:0] s_data,
  input  logic              s_last,
  output logic              coder_ce,
  output logic              coder_resetn,
  output logic [7:0]        coder_code,
  output logic [3:0]        coder_length,
  input  logic [31:0]       coder_word,
  input  logic              coder_valid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAD, DONE} state_e;

  state_e        state_q, state_d;
  logic [5:0]    acc_q, acc_d;
  logic          last_acc_q, last_acc_d;
  logic          p_valid_q, p_valid_d;
  logic          p_last_q, p_last_d;
  logic          err_q, err_d;
  logic          fly_q, fly_d;
  logic          fly_last_q, fly_last_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [11:0]   tbl_q [0:(1<<TBL_AW)-1];
  logic [11:0]   tbl_rd_q;
  logic [32:0]   fifo_q [0:FIFO_DEPTH-1];

  logic          accept, push, pop, credit_ok, p_bad;
  logic [3:0]    p_len, pad_len;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign p_len     = tbl_rd_q[11:8];
  assign p_bad     = (p_len == 4'd0) || (p_len > 4'd8);
  assign pad_len   = (acc_q <= 6'd24) ? 4'd8 : 4'(6'd32 - acc_q);
  // fly_q is the word the coder emitted last cycle, landing in the FIFO now
  assign credit_ok = (32'(cnt_q) + 32'(fly_q)) < FIFO_DEPTH;
  assign push      = fly_q;
  assign m_valid   = (cnt_q != '0);
  assign pop       = m_valid & m_ready;
  assign m_data    = fifo_q[rd_ptr_q][31:0];
  assign m_last    = m_valid & fifo_q[rd_ptr_q][32];
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    last_acc_d   = last_acc_q;
    p_valid_d    = p_valid_q;
    p_last_d     = p_last_q;
    err_d        = err_q;
    fly_d        = 1'b0;
    fly_last_d   = 1'b0;
    accept       = 1'b0;
    s_ready      = 1'b0;
    coder_ce     = 1'b0;
    coder_resetn = 1'b1;
    coder_code   = '0;
    coder_length = '0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          err_d   = 1'b0;
        end
      end
      CLEAR: begin
        coder_ce     = 1'b1;
        coder_resetn = 1'b0;
        acc_d        = '0;
        last_acc_d   = 1'b0;
        p_valid_d    = 1'b0;
        state_d      = RUN;
      end
      RUN: begin
        s_ready = !last_acc_q && credit_ok;
        accept  = s_valid && s_ready;
        if (p_valid_q) begin
          if (p_bad) begin
            err_d     = 1'b1;
            p_valid_d = 1'b0;
            if (p_last_q) state_d = PAD;
          end else if ((acc_q < 6'd32) || credit_ok) begin
            coder_ce     = 1'b1;
            coder_code   = tbl_rd_q[7:0];
            coder_length = p_len;
            if (acc_q >= 6'd32) begin
              fly_d = 1'b1;
              acc_d = acc_q - 6'd32 + {2'b00, p_len};
            end else begin
              acc_d = acc_q + {2'b00, p_len};
            end
            p_valid_d = 1'b0;
            if (p_last_q) state_d = PAD;
          end
        end
        // a held stage-2 beat implies !credit_ok, so accept never overwrites it
        if (accept) begin
          p_valid_d = 1'b1;
          p_last_d  = s_last;
          if (s_last) last_acc_d = 1'b1;
        end
      end
      PAD: begin
        if (acc_q >= 6'd32) begin
          if (credit_ok) begin
            coder_ce = 1'b1;
            fly_d    = 1'b1;
            acc_d    = acc_q - 6'd32;
            if (acc_q == 6'd32) begin
              fly_last_d = 1'b1;
              state_d    = DONE;
            end
          end
        end else if (acc_q == '0) begin
          state_d = DONE;
        end else begin
          coder_ce     = 1'b1;
          coder_length = pad_len;
          acc_d        = acc_q + {2'b00, pad_len};
        end
      end
      DONE: begin
        if (!fly_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      last_acc_q <= 1'b0;
      p_valid_q  <= 1'b0;
      p_last_q   <= 1'b0;
      err_q      <= 1'b0;
      fly_q      <= 1'b0;
      fly_last_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      last_acc_q <= last_acc_d;
      p_valid_q  <= p_valid_d;
      p_last_q   <= p_last_d;
      err_q      <= err_d;
      fly_q      <= fly_d;
      fly_last_q <= fly_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (tbl_we) tbl_q[tbl_addr] <= tbl_wdata;
    if (accept) tbl_rd_q <= tbl_q[s_data];
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= {fly_last_q, coder_word};
  end

  a_word_present: assert property (@(posedge clock) disable iff (!resetn) fly_q |-> coder_valid);

endmodule
